rf_param: RTL

//  Parametrised multi-register file: WIDTH-bit x REGS entries, 2 combinational

---
 rtl/rf_param.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rf_param.sv
// rf_param: parametrised architectural register file for the decode stage.
// Two combinational read ports and one write port. Options: write-to-read
// bypass and a hardwired-zero register 0. A bulk-clear engine zeroes one
// register per cycle in ascending order while writes are refused.
module rf_param #(
    parameter int WIDTH    = 16,
    parameter int REGS     = 8,
    parameter int SELW     = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SELW-1:0]  readReg1Sel,
    input  logic [SELW-1:0]  readReg2Sel,
    input  logic [SELW-1:0]  writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    input  logic             writeEn,
    input  logic             clrReq,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2,
    output logic             busy,
    output logic             err
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    // One bit wider than the select so REGS == 2**SELW still compares correctly
    localparam logic [SELW:0]   REGS_W = (SELW + 1)'(REGS);
    localparam logic [SELW-1:0] LAST   = SELW'(REGS - 1);

    state_t           state;
    logic [SELW-1:0]  cnt;
    logic [WIDTH-1:0] regs [REGS];

    logic writeInRange;
    logic writeZeroTarget;
    logic writeAccept;

    function automatic logic inRange(input logic [SELW-1:0] sel);
        return ({1'b0, sel} < REGS_W);
    endfunction

    function automatic logic isZeroReg(input logic [SELW-1:0] sel);
        return (ZERO_REG != 0) && (sel == '0);
    endfunction

    // Read mux: out-of-range and hardwired-zero reads give 0, bypass takes
    // priority over stored contents. Outputs are held at 0 while in reset.
    function automatic logic [WIDTH-1:0] readPort(input logic [SELW-1:0] sel);
        logic [WIDTH-1:0] value;
        value = '0;
        if (!rst || !inRange(sel) || isZeroReg(sel)) begin
            value = '0;
        end else if ((BYPASS != 0) && writeAccept && (writeRegSel == sel)) begin
            value = writeData;
        end else begin
            value = regs[sel];
        end
        return value;
    endfunction

    // Write qualification and rejection flag
    always_comb begin
        writeInRange    = inRange(writeRegSel);
        writeZeroTarget = isZeroReg(writeRegSel);
        writeAccept     = writeEn && (state == IDLE) && writeInRange && !writeZeroTarget;
        err             = rst && writeEn && ((state == CLEAR) || !writeInRange);
    end

    // Both read ports, independently bypassed
    always_comb begin
        readData1 = readPort(readReg1Sel);
        readData2 = readPort(readReg2Sel);
    end

    // Register array, clear sequencer and busy flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            for (int unsigned i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A write in the same cycle as clrReq still commits
                    if (writeAccept) begin
                        regs[writeRegSel] <= writeData;
                    end
                    if (clrReq) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs[cnt] <= '0;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
